// File: rtl/alu_nibble_seq_pkg.sv
// Shared types for the nibble ALU sequencer.
// ALU codes are the 4-bit {alu_sel, alu_cin} words.
package alu_nibble_seq_pkg;

  localparam logic [3:0] ALU_TRANSFER  = 4'b0000;
  localparam logic [3:0] ALU_INC       = 4'b0001;
  localparam logic [3:0] ALU_ADD_AB    = 4'b0010;
  localparam logic [3:0] ALU_ADD_ABCIN = 4'b0011;
  localparam logic [3:0] ALU_SUB_A_B   = 4'b0100;
  localparam logic [3:0] ALU_SUB_A_B_1 = 4'b0101;
  localparam logic [3:0] ALU_AND_MASK  = 4'b1000;
  localparam logic [3:0] ALU_OR_MASK   = 4'b1010;
  localparam logic [3:0] ALU_XOR_MASK  = 4'b1100;
  localparam logic [3:0] ALU_NOT_MASK  = 4'b1110;

  typedef enum logic [2:0] {
    SEQ_OP_PASS = 3'd0,
    SEQ_OP_ADD  = 3'd1,
    SEQ_OP_SUB  = 3'd2,
    SEQ_OP_INC  = 3'd3,
    SEQ_OP_AND  = 3'd4,
    SEQ_OP_OR   = 3'd5,
    SEQ_OP_XOR  = 3'd6,
    SEQ_OP_NOT  = 3'd7
  } seq_op_e;

  typedef enum logic [2:0] {
    SEQ_ST_IDLE = 3'd0,
    SEQ_ST_LO   = 3'd1,
    SEQ_ST_HI   = 3'd2,
    SEQ_ST_CAP  = 3'd3,
    SEQ_ST_DONE = 3'd4
  } seq_st_e;

  function automatic logic is_arith(
    input seq_op_e op
  );
    return !op[2];
  endfunction

endpackage

// File: rtl/alu_nibble_seq_if.sv
// Command / response handshake bundle between
// the CPU control unit and the nibble sequencer.
interface alu_nibble_seq_if;

  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_op;
  logic       req_wide;
  logic [7:0] req_a;
  logic [7:0] req_b;

  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_result;
  logic       rsp_carry;
  logic       rsp_zero;

  modport master (
    output req_valid, req_op, req_wide,
    output req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_result, rsp_carry, rsp_zero
  );

  modport slave (
    input  req_valid, req_op, req_wide,
    input  req_a, req_b, rsp_ready,
    output req_ready, rsp_valid,
    output rsp_result, rsp_carry, rsp_zero
  );

endinterface

// File: rtl/alu_nibble_seq_code_map.sv
// Maps (op, pass, low carry) to the 4-bit ALU code.
// Purely combinational.
module alu_nibble_seq_code_map
  import alu_nibble_seq_pkg::*;
(
  input  seq_op_e    op_i,
  input  logic       hi_i,
  input  logic       carry_lo_i,
  output logic [3:0] code_o
);

  logic chain;

  // High pass with a carry to absorb uses the
  // carry-consuming variant of the low code.
  assign chain = !hi_i || carry_lo_i;

  always_comb begin
    code_o = ALU_TRANSFER;
    unique case (op_i)
      SEQ_OP_PASS: code_o = ALU_TRANSFER;
      SEQ_OP_ADD: begin
        code_o = (hi_i && carry_lo_i)
               ? ALU_ADD_ABCIN : ALU_ADD_AB;
      end
      SEQ_OP_SUB: begin
        code_o = chain
               ? ALU_SUB_A_B_1 : ALU_SUB_A_B;
      end
      SEQ_OP_INC: begin
        code_o = chain ? ALU_INC : ALU_TRANSFER;
      end
      SEQ_OP_AND:  code_o = ALU_AND_MASK;
      SEQ_OP_OR:   code_o = ALU_OR_MASK;
      SEQ_OP_XOR:  code_o = ALU_XOR_MASK;
      SEQ_OP_NOT:  code_o = ALU_NOT_MASK;
    endcase
  end

endmodule

// File: rtl/alu_nibble_seq.sv
// Sequences 8/4-bit ops as nibble passes through
// the registered 4-bit ALU, low carry chained high.
module alu_nibble_seq
  import alu_nibble_seq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  alu_nibble_seq_if.slave  bus,
  output logic [3:0]       alu_a,
  output logic [3:0]       alu_b,
  output logic [2:0]       alu_sel,
  output logic             alu_cin,
  input  logic [3:0]       alu_out,
  input  logic             alu_cout
);

  seq_st_e    state_q, state_d;
  seq_op_e    op_q, op_d;
  logic       wide_q, wide_d;
  logic [7:0] a_q, a_d;
  logic [7:0] b_q, b_d;
  logic [7:0] result_q, result_d;
  logic       carry_q, carry_d;
  logic       zero_q, zero_d;

  logic [3:0] map_code;
  logic [3:0] code;
  logic [7:0] cap;

  alu_nibble_seq_code_map u_map (
    .op_i       (op_q),
    .hi_i       (state_q == SEQ_ST_HI),
    .carry_lo_i (alu_cout),
    .code_o     (map_code)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= SEQ_ST_IDLE;
      op_q     <= SEQ_OP_PASS;
      wide_q   <= 1'b0;
      a_q      <= 8'h00;
      b_q      <= 8'h00;
      result_q <= 8'h00;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wide_q   <= wide_d;
      a_q      <= a_d;
      b_q      <= b_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    wide_d   = wide_q;
    a_d      = a_q;
    b_d      = b_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    alu_a    = 4'h0;
    alu_b    = 4'h0;
    code     = ALU_TRANSFER;
    cap      = 8'h00;
    unique case (state_q)
      SEQ_ST_IDLE: begin
        if (bus.req_valid) begin
          op_d    = seq_op_e'(bus.req_op);
          wide_d  = bus.req_wide;
          a_d     = bus.req_a;
          b_d     = bus.req_b;
          state_d = SEQ_ST_LO;
        end
      end
      SEQ_ST_LO: begin
        alu_a   = a_q[3:0];
        alu_b   = b_q[3:0];
        code    = map_code;
        state_d = wide_q ? SEQ_ST_HI
                         : SEQ_ST_CAP;
      end
      SEQ_ST_HI: begin
        alu_a         = a_q[7:4];
        alu_b         = b_q[7:4];
        code          = map_code;
        result_d[3:0] = alu_out;
        state_d       = SEQ_ST_CAP;
      end
      SEQ_ST_CAP: begin
        cap = wide_q
            ? {alu_out, result_q[3:0]}
            : {4'h0, alu_out};
        result_d = cap;
        carry_d  = is_arith(op_q) & alu_cout;
        zero_d   = (cap == 8'h00);
        state_d  = SEQ_ST_DONE;
      end
      SEQ_ST_DONE: begin
        if (bus.rsp_ready) state_d = SEQ_ST_IDLE;
      end
      default: state_d = SEQ_ST_IDLE;
    endcase
  end

  assign alu_sel = code[3:1];
  assign alu_cin = code[0];

  assign bus.req_ready  = (state_q == SEQ_ST_IDLE);
  assign bus.rsp_valid  = (state_q == SEQ_ST_DONE);
  assign bus.rsp_result = result_q;
  assign bus.rsp_carry  = carry_q;
  assign bus.rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_nibble_seq.sv
// Scoreboard bench for alu_nibble_seq with an
// emulated registered 4-bit ALU on its ALU ports.
module tb_alu_nibble_seq;
  import alu_nibble_seq_pkg::*;

  typedef struct {
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       w;
    int         t;
  } exp_t;

  logic       clk;
  logic       rst;
  logic [3:0] alu_a, alu_b, alu_out;
  logic [2:0] alu_sel;
  logic       alu_cin, alu_cout;
  logic [4:0] alu_nx;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   force_hold = -1;
  exp_t exp_q[$];

  alu_nibble_seq_if bus ();

  alu_nibble_seq dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_sel  (alu_sel),
    .alu_cin  (alu_cin),
    .alu_out  (alu_out),
    .alu_cout (alu_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the existing registered ALU.
  always_comb begin
    alu_nx = 5'd0;
    case ({alu_sel, alu_cin})
      ALU_TRANSFER:  alu_nx = {1'b0, alu_a};
      ALU_INC:       alu_nx = {1'b0, alu_a} + 5'd1;
      ALU_ADD_AB:    alu_nx = alu_a + alu_b;
      ALU_ADD_ABCIN: alu_nx = alu_a + alu_b + 5'd1;
      ALU_SUB_A_B:   alu_nx = alu_a + {1'b0, ~alu_b};
      ALU_SUB_A_B_1: alu_nx = alu_a + {1'b0, ~alu_b} + 5'd1;
      ALU_AND_MASK:  alu_nx = {1'b0, alu_a & alu_b};
      ALU_OR_MASK:   alu_nx = {1'b0, alu_a | alu_b};
      ALU_XOR_MASK:  alu_nx = {1'b0, alu_a ^ alu_b};
      ALU_NOT_MASK:  alu_nx = {1'b0, ~alu_a};
      default:       alu_nx = 5'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_out  <= 4'h0;
      alu_cout <= 1'b0;
    end else begin
      alu_out  <= alu_nx[3:0];
      alu_cout <= alu_nx[4];
    end
  end

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h t=%0t",
               n, act, exp, $time);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op,
                                 input logic w,
                                 input logic [7:0] a,
                                 input logic [7:0] b);
    exp_t e;
    int unsigned x, y, r, m;
    m = w ? 256 : 16;
    x = w ? a : a % 16;
    y = w ? b : b % 16;
    case (op)
      3'd0: r = x;
      3'd1: r = x + y;
      3'd2: r = x + m - y;
      3'd3: r = x + 1;
      3'd4: r = x & y;
      3'd5: r = x | y;
      3'd6: r = x ^ y;
      default: r = (m - 1) - x;
    endcase
    e.res = 8'(r % m);
    e.c   = (op inside {3'd1, 3'd2, 3'd3}) && (r >= m);
    e.z   = (r % m) == 0;
    e.w   = w;
    e.t   = 0;
    return e;
  endfunction

  task automatic issue(input logic [2:0] op,
                       input logic w,
                       input logic [7:0] a,
                       input logic [7:0] b);
    exp_t e;
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("req_wait", bus.req_ready, 1'b1);
    if (!bus.req_ready) return;
    bus.req_op    = op;
    bus.req_wide  = w;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    @(posedge clk);
    #1;
    e   = model(op, w, a, b);
    e.t = cyc;
    exp_q.push_back(e);
    bus.req_valid = 1'b0;
    bus.req_op    = 3'($urandom);
    bus.req_wide  = 1'($urandom);
    bus.req_a     = 8'($urandom);
    bus.req_b     = 8'($urandom);
  endtask

  // Monitor: pops on each response, checks hold.
  initial begin
    exp_t e;
    int   hold;
    bus.rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && bus.rsp_valid) begin
        chk("rsp_expected", exp_q.size() > 0, 1'b1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("latency", cyc - e.t, e.w ? 3 : 2);
          chk("result", bus.rsp_result, e.res);
          chk("carry", bus.rsp_carry, e.c);
          chk("zero", bus.rsp_zero, e.z);
          hold = (force_hold >= 0) ? force_hold
                 : int'($urandom_range(0, 3));
          force_hold = -1;
          repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", bus.rsp_valid, 1'b1);
            chk("hold_ready", bus.req_ready, 1'b0);
            chk("hold_result", bus.rsp_result, e.res);
            chk("hold_carry", bus.rsp_carry, e.c);
            chk("hold_zero", bus.rsp_zero, e.z);
          end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        @(negedge clk);
        chk("post_valid", bus.rsp_valid, 1'b0);
        chk("post_idle", bus.req_ready, 1'b1);
      end
    end
  end

  task automatic chk_reset_vals(input string n);
    chk({n, "_req_ready"}, bus.req_ready, 1'b1);
    chk({n, "_rsp_valid"}, bus.rsp_valid, 1'b0);
    chk({n, "_result"}, bus.rsp_result, 8'h00);
    chk({n, "_carry"}, bus.rsp_carry, 1'b0);
    chk({n, "_zero"}, bus.rsp_zero, 1'b0);
    chk({n, "_alu_ab"}, {alu_a, alu_b}, 8'h00);
    chk({n, "_code"}, {alu_sel, alu_cin}, ALU_TRANSFER);
  endtask

  initial begin
    int n;
    rst           = 1'b0;
    bus.req_valid = 1'b0;
    bus.req_op    = 3'd0;
    bus.req_wide  = 1'b0;
    bus.req_a     = 8'h00;
    bus.req_b     = 8'h00;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    rst = 1'b1;

    issue(3'd1, 1'b1, 8'h3C, 8'h0F);
    @(negedge clk);
    chk("lo_code", {alu_sel, alu_cin}, ALU_ADD_AB);
    chk("lo_ops", {alu_a, alu_b}, 8'hCF);
    @(negedge clk);
    chk("hi_code", {alu_sel, alu_cin}, ALU_ADD_ABCIN);
    chk("hi_ops", {alu_a, alu_b}, 8'h30);

    issue(3'd1, 1'b1, 8'hFF, 8'h01);
    issue(3'd2, 1'b1, 8'h50, 8'h01);
    issue(3'd2, 1'b1, 8'h01, 8'h02);
    issue(3'd3, 1'b0, 8'hAF, 8'h33);
    issue(3'd7, 1'b0, 8'h5F, 8'h00);
    force_hold = 4;
    issue(3'd6, 1'b1, 8'hA5, 8'hFF);

    issue(3'd1, 1'b1, 8'h12, 8'h34);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk_reset_vals("midop");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("no_rsp", bus.rsp_valid, 1'b0);
    end

    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(3'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom));
    end

    n = 0;
    while ((exp_q.size() != 0 || !bus.req_ready)
           && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog act=running exp=done");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_nibble_seq.md
# alu_nibble_seq

Multi-cycle sequencer for the registered 4-bit ALU that executes 8-bit (or 4-bit) operations for one requester. Each operation is split into nibble passes through the ALU, with the low-nibble carry chained into the high-nibble opcode. The block accepts a command over a valid/ready handshake and returns the result, carry and zero flags over a held response handshake. It sits between the CPU control unit and the ALU; the CPU top connects the ALU ports.

## Interface
Parameters: none (widths fixed by the 4-bit ALU).
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when valid & ready
- req_op  in  3  000 PASS, 001 ADD, 010 SUB (a-b), 011 INC (a+1), 100 AND, 101 OR, 110 XOR, 111 NOT (~a)
- req_wide  in  1  1 = 8-bit operation (two passes), 0 = 4-bit (low nibble only)
- req_a, req_b  in  8  operands; upper nibble ignored when req_wide=0
- rsp_valid  out  1  result valid, held until rsp_ready
- rsp_ready  in  1  requester takes result
- rsp_result  out  8  result; upper nibble 0 when 4-bit
- rsp_carry  out  1  carry out of last arithmetic pass (SUB: 1 = no borrow); 0 for logic ops
- rsp_zero  out  1  rsp_result == 0
- alu_a, alu_b  out  4  ALU operands
- alu_sel  out  3  ALU select; {alu_sel, alu_cin} is a 4-bit ALU code
- alu_cin  out  1  ALU carry-in / code LSB
- alu_out  in  4  registered ALU result (valid 1 cycle after issue)
- alu_cout  in  1  registered ALU carry

## Operation
- States: IDLE, LO, HI, CAP, DONE. req_ready = (state==IDLE).
- IDLE: on req_valid, latch op/wide/a/b and go to LO.
- LO: drive alu_a=a[3:0], alu_b=b[3:0], low code; go to HI if wide, else CAP_LO (= CAP with hi skipped; a flag selects).
- HI: capture alu_out into result[3:0] and alu_cout into carry_lo; drive a[7:4], b[7:4] and the high code, chosen from combinational alu_cout; go to CAP.
- CAP: capture alu_out into result[7:4] (wide) or result[3:0] (narrow, upper nibble forced 0); carry = alu_cout (arith) or 0 (logic); go to DONE.
- DONE: rsp_valid=1, outputs stable; on rsp_ready go to IDLE. No acceptance in the same cycle.
- Low code: PASS→ALU_TRANSFER, ADD→ALU_ADD_AB, SUB→ALU_SUB_A_B_1, INC→ALU_INC, AND/OR/XOR/NOT→ALU_*_MASK with cin=0.
- High code (arith): carry_lo=1 → ADD_ABCIN / SUB_A_B_1 / INC / TRANSFER; carry_lo=0 → ADD_AB / SUB_A_B / TRANSFER / TRANSFER. Logic ops use the same code as the low pass.
- Outside LO/HI, drive alu_a=alu_b=0 with code ALU_TRANSFER.
- rsp_zero is computed on the captured 8-bit result.

## Timing
- Reset (async, rst=0): state IDLE, req_ready=1, rsp_valid=0, rsp_result=0, rsp_carry=0, rsp_zero=0, alu_a=alu_b=0, code ALU_TRANSFER. Reset applies immediately, including mid-operation; the in-flight command is dropped with no response.
- Accept at edge k. rsp_valid rises after edge k+3 (wide) or edge k+2 (narrow).
- rsp_valid stays high and the result stays stable while rsp_ready=0. The state returns to IDLE one cycle after the rsp_ready handshake, so throughput is one op per 5 cycles (wide).
- req_* changes while busy are ignored, because operands are latched at acceptance.

## Structure
- cpu_defs.vh: ALU code macros (existing), plus new SEQ_OP_* op encodings and SEQ_ST_* state encodings.
- One natural sub-module: alu_code_map, purely combinational. It maps (op, is_high_pass, carry_lo) to the 4-bit {alu_sel, cin} code.
- The sequencer does not instantiate the ALU; the CPU top wires them together.

## Test plan
- Wide ADD 0x3C+0x0F → result 0x4B, carry 0, zero 0; rsp_valid 3 cycles after accept; high pass issued with ADD_ABCIN.
- Wide ADD 0xFF+0x01 → result 0x00, carry 1, zero 1.
- Wide SUB 0x50-0x01 → 0x4F, carry 1. Wide SUB 0x01-0x02 → 0xFF, carry 0.
- Narrow INC a=0xF → result 0x00, carry 1, zero 1, rsp_valid 2 cycles after accept. Wide XOR 0xA5^0xFF → 0x5A, carry 0.
- Hold rsp_ready=0 for 4 cycles → result stable, req_ready=0. Then assert rst mid-LO of the next op → all outputs return to reset values immediately, with no response.
